store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port St_Valid  in  1  store request from execute stage.
REQ-005 SHALL have ports St_Addr, St_Data  in  8 each  store address and data.
REQ-006 SHALL have port Ld_Valid  in  1  load request from execute stage.
REQ-007 SHALL have port Ld_Addr  in  8  load address.
REQ-008 SHALL have ports Mem_Write_EN, Mem_Read_EN  out  1 each  data memory strobes.
REQ-009 SHALL have ports Mem_A, Mem_WD  out  8 each  data memory address and write data.
REQ-010 SHALL have port Mem_RD  in  8  data memory read data, valid one cycle after Mem_Read_EN.
REQ-011 SHALL have ports Ld_Data  out  8  and Ld_Done  out  1  load result and its qualifier.
REQ-012 SHALL have ports Stall  out  1  (request not accepted, hold inputs) and Empty  out  1  (no buffered stores).

Function
REQ-013 SHALL hold stores in a circular FIFO of DEPTH entries (addr, data) with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-014 SHALL give the memory port to a load that misses the buffer; otherwise, if non-empty, SHALL drain the head entry (Mem_Write_EN=1, Mem_A/Mem_WD=head) and pop it that cycle.
REQ-015 Mem_* outputs SHALL be combinational from current state and requests; Mem_Write_EN and Mem_Read_EN SHALL never both be 1.
REQ-016 An accepted store SHALL be pushed at the tail at the clock edge; push and drain-pop in the same cycle SHALL both occur, including when full.
REQ-017 Store SHALL be refused (Stall=1) only when count==DEPTH and no drain occurs that cycle.
REQ-018 Load hit = Ld_Addr equals the address of any valid entry present before this cycle's push; the youngest matching entry SHALL win.
REQ-019 Load miss: Mem_Read_EN=1, Mem_A=Ld_Addr; next cycle Ld_Done=1, Ld_Data=Mem_RD.
REQ-020 Load latency SHALL be exactly one cycle for both hit and miss; Ld_Done SHALL be a one-cycle pulse per accepted load.
REQ-021 A same-cycle store SHALL NOT be visible to a same-cycle load (load is older in program order).
REQ-022 Stall SHALL be high while either a store or a load is refused; refused requests have no side effect and upstream re-presents them.
REQ-023 Empty SHALL equal (count==0).

Reset
REQ-024 On RST=1 at a clock edge: count, head, tail SHALL clear to 0; Ld_Done and Ld_Data SHALL be 0 the following cycle; Empty=1.
REQ-025 Stores buffered at reset, including one presented in the reset cycle, SHALL be discarded; entry storage need not be cleared.
REQ-026 While RST=1 no request SHALL be accepted and Mem_Write_EN/Mem_Read_EN SHALL be 0.

Configuration
REQ-027 Macro STORE_BUFFER_FWD_EN defined: load hits SHALL forward the youngest matching entry's data (Ld_Done next cycle, no memory read) per REQ-018.
REQ-028 Macro undefined: a load hit SHALL be refused (Stall=1) and the head SHALL drain that cycle; the load is accepted once no match remains; misses unchanged.

Structure
REQ-029 Package sb_pkg SHALL hold ADDR_W=8, DATA_W=8, DEFAULT_DEPTH=4 and the entry typedef {addr, data}.
REQ-030 Sub-module sb_match SHALL implement the age-ordered address compare returning hit and youngest-entry index.

Verification
REQ-031 Reset, then store 0x10<-0xAA with no loads -> next cycle Mem_Write_EN=1, Mem_A=0x10, Mem_WD=0xAA; Empty=1 afterwards.
REQ-032 Fill 4 stores while 4 consecutive loads to 0x80 (miss) occupy the port -> fifth store Stall=1, no drain; after loads stop, drain in FIFO order.
REQ-033 Stores 0x20<-0x11 then 0x20<-0x22 buffered, load 0x20 -> with FWD_EN Ld_Data=0x22, Mem_Read_EN=0; without, Stall until both drained, then read 0x22.
REQ-034 Same-cycle store 0x30<-0x55 and load 0x30 (memory holds 0x00) -> Ld_Data=0x00; store buffered.
REQ-035 Full buffer, store presented with no load -> push and pop same cycle, count stays 4, pointers wrap.
REQ-036 Assert RST with 3 stores buffered -> Empty=1 next cycle, no Mem_Write_EN for discarded entries.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared widths and the buffered-store entry type for the store buffer.
package sb_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Execute-stage request and data-memory bus of the store buffer.
interface store_buffer_if;
  import sb_pkg::*;

  logic              St_Valid;
  logic [ADDR_W-1:0] St_Addr;
  logic [DATA_W-1:0] St_Data;
  logic              Ld_Valid;
  logic [ADDR_W-1:0] Ld_Addr;
  logic              Mem_Write_EN;
  logic              Mem_Read_EN;
  logic [ADDR_W-1:0] Mem_A;
  logic [DATA_W-1:0] Mem_WD;
  logic [DATA_W-1:0] Mem_RD;
  logic [DATA_W-1:0] Ld_Data;
  logic              Ld_Done;
  logic              Stall;
  logic              Empty;

  modport master (
    output St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_RD,
    input  Mem_Write_EN, Mem_Read_EN, Mem_A, Mem_WD, Ld_Data, Ld_Done, Stall, Empty
  );

  modport slave (
    input  St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_RD,
    output Mem_Write_EN, Mem_Read_EN, Mem_A, Mem_WD, Ld_Data, Ld_Done, Stall, Empty
  );

endinterface

// File: rtl/sb_match.sv
// Age-ordered address compare over the valid FIFO entries; reports a hit and
// the index of the youngest matching entry.
module sb_match
  import sb_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [PTR_W-1:0]  hit_idx
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (((PTR_W+1)'(k) < count) && (entries[idx].addr == addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer sharing one data-memory port between load misses and drains.
// Define STORE_BUFFER_FWD_EN to forward load hits; otherwise hits stall until drained.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic           CLK,
  input logic           RST,
  store_buffer_if.slave sb
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t         entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;

  logic              ld_hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              ld_read;
  logic              ld_fwd;
  logic              ld_accept;
  logic              drain;
  logic              st_accept;

  logic              ld_done_q;
  logic              ld_fwd_q;
  logic [DATA_W-1:0] fwd_data_q;

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (sb.Ld_Addr),
    .hit     (ld_hit),
    .hit_idx (hit_idx)
  );

  // A load miss owns the memory port; the head drains whenever the port is free.
  always_comb begin
    ld_read   = 1'b0;
    ld_fwd    = 1'b0;
    ld_accept = 1'b0;
    drain     = 1'b0;
    st_accept = 1'b0;
    if (!RST) begin
      ld_read = sb.Ld_Valid && !ld_hit;
`ifdef STORE_BUFFER_FWD_EN
      ld_fwd    = sb.Ld_Valid && ld_hit;
      ld_accept = sb.Ld_Valid;
`else
      ld_accept = ld_read;
`endif
      drain     = (count != '0) && !ld_read;
      st_accept = sb.St_Valid && ((count != (PTR_W+1)'(DEPTH)) || drain);
    end
  end

  assign sb.Mem_Read_EN  = ld_read;
  assign sb.Mem_Write_EN = drain;
  assign sb.Mem_A        = ld_read ? sb.Ld_Addr : entries[head].addr;
  assign sb.Mem_WD       = entries[head].data;
  assign sb.Stall        = (sb.St_Valid && !st_accept) || (sb.Ld_Valid && !ld_accept);
  assign sb.Empty        = (count == '0);
  assign sb.Ld_Done      = ld_done_q;
  assign sb.Ld_Data      = !ld_done_q ? '0 : (ld_fwd_q ? fwd_data_q : sb.Mem_RD);

  always_ff @(posedge CLK) begin
    if (st_accept) begin
      entries[tail] <= '{addr: sb.St_Addr, data: sb.St_Data};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ld_done_q  <= 1'b0;
      ld_fwd_q   <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      if (st_accept) tail <= tail + PTR_W'(1);
      if (drain)     head <= head + PTR_W'(1);
      count     <= count + (PTR_W+1)'(st_accept) - (PTR_W+1)'(drain);
      ld_done_q <= ld_accept;
      ld_fwd_q  <= ld_fwd;
      if (ld_fwd) fwd_data_q <= entries[hit_idx].data;
    end
  end

endmodule
